// File: rtl/level_progress_fsm.sv
// level_progress_fsm: score accumulation, level timer and level progression
// for the game. It consumes the collision hit pulse and drives the game-state
// flags plus the score, level, timer and target displays.
module level_progress_fsm #(
   parameter int FRAMES_PER_SEC = 30,
   parameter int LEVEL_TIME     = 60,
   parameter int BASE_TARGET    = 100,
   parameter int TARGET_STEP    = 75,
   parameter int MAX_LEVEL      = 4,
   parameter int CLEAR_FRAMES   = 90
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        startOfFrame,
   input  logic        start_game,
   input  logic        SingleHitPulse,
   input  logic [7:0]  hit_value,
   output logic [15:0] score,
   output logic [3:0]  level,
   output logic [7:0]  time_left,
   output logic [15:0] target,
   output logic        playing,
   output logic        level_cleared_pulse,
   output logic        game_over,
   output logic        game_won
);

   localparam int FW = $clog2(FRAMES_PER_SEC + 1);
   localparam int CW = $clog2(CLEAR_FRAMES + 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
   localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_FRAMES - 1);
   localparam logic [7:0]    TIME_INIT  = 8'(LEVEL_TIME);
   localparam logic [3:0]    LVL_MAX    = 4'(MAX_LEVEL);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PLAY  = 3'd1,
      S_CLEAR = 3'd2,
      S_LOSE  = 3'd3,
      S_WIN   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [15:0]     score_q, score_d;
   logic [3:0]      level_q, level_d;
   logic [7:0]      time_q, time_d;
   logic [FW-1:0]   frame_q, frame_d;
   logic [CW-1:0]   clear_q, clear_d;
   logic            playing_q, playing_d;
   logic            pulse_q, pulse_d;
   logic            over_q, over_d;
   logic            won_q, won_d;

   logic [16:0]     hit_sum;
   logic [15:0]     score_next;
   logic            sec_tick;

   // Target grows linearly with the level index.
   assign target = 16'(BASE_TARGET) + 16'(level_q) * 16'(TARGET_STEP);

   // State and datapath registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         score_q   <= 16'd0;
         level_q   <= 4'd0;
         time_q    <= TIME_INIT;
         frame_q   <= '0;
         clear_q   <= '0;
         playing_q <= 1'b0;
         pulse_q   <= 1'b0;
         over_q    <= 1'b0;
         won_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         score_q   <= score_d;
         level_q   <= level_d;
         time_q    <= time_d;
         frame_q   <= frame_d;
         clear_q   <= clear_d;
         playing_q <= playing_d;
         pulse_q   <= pulse_d;
         over_q    <= over_d;
         won_q     <= won_d;
      end
   end

   // Next-state and datapath: hit accumulation, second timer, level transitions.
   always_comb begin
      state_d = state_q;
      score_d = score_q;
      level_d = level_q;
      time_d  = time_q;
      frame_d = frame_q;
      clear_d = clear_q;

      // Saturating add; score_next already includes a same-cycle hit so the
      // final-tick comparison sees it.
      hit_sum    = {1'b0, score_q} + {9'd0, hit_value};
      score_next = SingleHitPulse ? (hit_sum[16] ? 16'hFFFF : hit_sum[15:0]) : score_q;
      sec_tick   = startOfFrame && (frame_q == FRAME_LAST);

      case (state_q)
         S_IDLE: begin
            if (start_game) begin
               state_d = S_PLAY;
               score_d = 16'd0;
               level_d = 4'd0;
               time_d  = TIME_INIT;
               frame_d = '0;
               clear_d = '0;
            end
         end
         S_PLAY: begin
            score_d = score_next;
            if (startOfFrame) frame_d = sec_tick ? '0 : frame_q + FW'(1);
            if (sec_tick && time_q != 8'd0) begin
               time_d = time_q - 8'd1;
               if (time_q == 8'd1) begin
                  clear_d = '0;
                  if (score_next >= target)
                     state_d = (level_q < LVL_MAX) ? S_CLEAR : S_WIN;
                  else
                     state_d = S_LOSE;
               end
            end
         end
         S_CLEAR: begin
            if (startOfFrame) begin
               if (clear_q == CLEAR_LAST) begin
                  clear_d = '0;
                  frame_d = '0;
                  time_d  = TIME_INIT;
                  level_d = (level_q < LVL_MAX) ? level_q + 4'd1 : level_q;
                  state_d = S_PLAY;
               end else begin
                  clear_d = clear_q + CW'(1);
               end
            end
         end
         S_LOSE, S_WIN: begin
            if (start_game) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Flag outputs, registered from the upcoming state.
   always_comb begin
      playing_d = (state_d == S_PLAY);
      pulse_d   = (state_q == S_PLAY) && (state_d == S_CLEAR);
      over_d    = (state_d == S_LOSE);
      won_d     = (state_d == S_WIN);
   end

   assign score               = score_q;
   assign level               = level_q;
   assign time_left           = time_q;
   assign playing             = playing_q;
   assign level_cleared_pulse = pulse_q;
   assign game_over           = over_q;
   assign game_won            = won_q;

endmodule

// File: tb/tb_level_progress_fsm.sv
// Directed bench for level_progress_fsm with a short timer
// (LEVEL_TIME=3, FRAMES_PER_SEC=2).
module tb_level_progress_fsm;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        startOfFrame = 1'b0;
   logic        start_game = 1'b0;
   logic        SingleHitPulse = 1'b0;
   logic [7:0]  hit_value = 8'd0;
   logic [15:0] score;
   logic [3:0]  level;
   logic [7:0]  time_left;
   logic [15:0] target;
   logic        playing;
   logic        level_cleared_pulse;
   logic        game_over;
   logic        game_won;

   int n_chk = 0;
   int n_fail = 0;

   level_progress_fsm #(
      .FRAMES_PER_SEC(2),
      .LEVEL_TIME(3),
      .BASE_TARGET(100),
      .TARGET_STEP(75),
      .MAX_LEVEL(4),
      .CLEAR_FRAMES(90)
   ) dut (
      .clk(clk),
      .reset(reset),
      .startOfFrame(startOfFrame),
      .start_game(start_game),
      .SingleHitPulse(SingleHitPulse),
      .hit_value(hit_value),
      .score(score),
      .level(level),
      .time_left(time_left),
      .target(target),
      .playing(playing),
      .level_cleared_pulse(level_cleared_pulse),
      .game_over(game_over),
      .game_won(game_won)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
   endtask

   task automatic hit(input logic [7:0] v);
      SingleHitPulse = 1'b1;
      hit_value = v;
      step();
      SingleHitPulse = 1'b0;
      hit_value = 8'd0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic start();
      start_game = 1'b1;
      step();
      start_game = 1'b0;
   endtask

   initial begin
      // Reset state
      step(); step();
      reset = 1'b0;
      chk("rst_score", 32'(score), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_time", 32'(time_left), 32'd3);
      chk("rst_target", 32'(target), 32'd100);
      chk("rst_flags", {28'd0, playing, level_cleared_pulse, game_over, game_won}, 32'd0);

      // Start and scoring, each hit visible one cycle later
      start();
      chk("start_playing", 32'(playing), 32'd1);
      chk("start_score", 32'(score), 32'd0);
      hit(8'd40);
      chk("hit40", 32'(score), 32'd40);
      hit(8'd250);
      chk("hit250", 32'(score), 32'd290);
      hit(8'd30);
      chk("hit30", 32'(score), 32'd320);

      // Reset mid-play from a fresh game
      reset = 1'b1; step(); reset = 1'b0;
      chk("rst2_score", 32'(score), 32'd0);
      chk("rst2_playing", 32'(playing), 32'd0);

      // Level clear with score exactly at target
      start();
      hit(8'd60);
      hit(8'd40);
      chk("lc_score", 32'(score), 32'd100);
      frame();
      chk("lc_t_f1", 32'(time_left), 32'd3);
      frame();
      chk("lc_t_f2", 32'(time_left), 32'd2);
      frames(2);
      chk("lc_t_f4", 32'(time_left), 32'd1);
      frames(2);
      chk("lc_t_f6", 32'(time_left), 32'd0);
      chk("lc_pulse", 32'(level_cleared_pulse), 32'd1);
      chk("lc_playing", 32'(playing), 32'd0);
      step();
      chk("lc_pulse_1cyc", 32'(level_cleared_pulse), 32'd0);
      hit(8'd50);
      chk("lc_hit_ignored", 32'(score), 32'd100);
      frames(89);
      chk("lc_89_level", 32'(level), 32'd0);
      chk("lc_89_playing", 32'(playing), 32'd0);
      frame();
      chk("lc_90_level", 32'(level), 32'd1);
      chk("lc_90_target", 32'(target), 32'd175);
      chk("lc_90_time", 32'(time_left), 32'd3);
      chk("lc_90_score", 32'(score), 32'd100);
      chk("lc_90_playing", 32'(playing), 32'd1);

      // Reset mid-level at level 1 with partial timer
      frames(2);
      chk("l1_time", 32'(time_left), 32'd2);
      reset = 1'b1; step(); reset = 1'b0;
      chk("rst3_level", 32'(level), 32'd0);
      chk("rst3_time", 32'(time_left), 32'd3);
      chk("rst3_score", 32'(score), 32'd0);
      chk("rst3_target", 32'(target), 32'd100);

      // Loss with score one short, then held-key restart
      start();
      hit(8'd99);
      frames(6);
      chk("lose_over", 32'(game_over), 32'd1);
      chk("lose_playing", 32'(playing), 32'd0);
      chk("lose_time", 32'(time_left), 32'd0);
      hit(8'd50);
      chk("lose_hit_ignored", 32'(score), 32'd99);
      frames(4);
      chk("lose_time_hold", 32'(time_left), 32'd0);
      start_game = 1'b1;
      step();
      chk("restart_idle_over", 32'(game_over), 32'd0);
      chk("restart_idle_playing", 32'(playing), 32'd0);
      chk("restart_idle_score", 32'(score), 32'd99);
      step();
      start_game = 1'b0;
      chk("restart_play", 32'(playing), 32'd1);
      chk("restart_score", 32'(score), 32'd0);

      // Hit on the same clock as the final tick counts toward the target
      hit(8'd90);
      frames(5);
      chk("sim_pre_time", 32'(time_left), 32'd1);
      SingleHitPulse = 1'b1; hit_value = 8'd10;
      frame();
      SingleHitPulse = 1'b0; hit_value = 8'd0;
      chk("sim_pulse", 32'(level_cleared_pulse), 32'd1);
      chk("sim_score", 32'(score), 32'd100);
      chk("sim_over", 32'(game_over), 32'd0);
      frames(90);
      chk("sim_level", 32'(level), 32'd1);

      // Pump score to 65530, then clear levels 1..3 to reach level 4
      for (int i = 0; i < 256; i++) hit(8'd255);
      hit(8'd150);
      chk("pump_score", 32'(score), 32'd65530);
      for (int l = 1; l < 4; l++) begin
         frames(6);
         chk("adv_pulse", 32'(level_cleared_pulse), 32'd1);
         frames(90);
      end
      chk("l4_level", 32'(level), 32'd4);
      chk("l4_target", 32'(target), 32'd400);
      chk("l4_playing", 32'(playing), 32'd1);

      // Saturation and win
      hit(8'd200);
      chk("sat_score", 32'(score), 32'd65535);
      hit(8'd5);
      chk("sat_hold", 32'(score), 32'd65535);
      frames(6);
      chk("win_won", 32'(game_won), 32'd1);
      chk("win_pulse", 32'(level_cleared_pulse), 32'd0);
      chk("win_level", 32'(level), 32'd4);
      chk("win_playing", 32'(playing), 32'd0);
      chk("win_over", 32'(game_over), 32'd0);
      frames(200);
      chk("win_level_hold", 32'(level), 32'd4);
      chk("win_time_hold", 32'(time_left), 32'd0);
      chk("win_won_hold", 32'(game_won), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
